// File: rtl/piano_phase_acc_if.sv
// Note-step handshake plus the operand/result bus to the external 8-bit adder.
// master: note source and adder side; slave: the phase sequencer.
interface piano_phase_acc_if #(
    parameter int W = 8
);
    logic         note_valid;
    logic         note_ready;
    logic [W-1:0] note_step;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_res;

    modport master (
        output note_valid, note_step, add_res,
        input  note_ready, add_a, add_b
    );

    modport slave (
        input  note_valid, note_step, add_res,
        output note_ready, add_a, add_b
    );
endinterface

// File: rtl/piano_phase_acc.sv
// Tone-phase sequencer: feeds accumulator and step to an external adder,
// registers the sum once per sample tick, and toggles a square wave on
// every phase wrap. On release the tone is allowed to finish its high half
// so it always ends low.
module piano_phase_acc #(
    parameter int W   = 8,
    parameter int DIV = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    piano_phase_acc_if.slave   bus,
    input  logic               key_on,
    output logic               tone,
    output logic               wrap,
    output logic               busy
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [W-1:0]  step_r;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          run_ph;
    logic          xfer;
    logic          wrapped;
    logic [W-1:0]  eff_step;

    assign tick   = (cnt == CW'(DIV - 1));
    assign run_ph = (state == S_RUN) || (state == S_REL);
    assign busy   = (state != S_IDLE);

    // A note may not be swapped while the tone is winding down.
    assign bus.note_ready = (state != S_REL);
    assign xfer           = bus.note_valid & bus.note_ready;

    // A step arriving in the same cycle as key_on counts for IDLE exit.
    assign eff_step = xfer ? bus.note_step : step_r;

    assign bus.add_a = acc;
    assign bus.add_b = run_ph ? step_r : '0;

    // The sum is mod 2^W, so it is smaller than acc exactly when it wrapped.
    assign wrapped = (bus.add_res < acc);

    // Free-running sample tick divider, independent of the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Step register: any accepted handshake loads the new step word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    step_r <= '0;
        else if (xfer) step_r <= bus.note_step;
    end

    // Sequencer FSM with accumulator, tone and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            tone  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_on && (eff_step != '0)) begin
                        state <= S_RUN;
                        acc   <= '0;
                        tone  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A zero step silences the note at once.
                    if (xfer && (bus.note_step == '0)) begin
                        state <= S_IDLE;
                        acc   <= '0;
                        tone  <= 1'b0;
                    end else begin
                        if (tick) begin
                            acc <= bus.add_res;
                            if (wrapped) begin
                                wrap <= 1'b1;
                                tone <= ~tone;
                            end
                        end
                        if (!key_on) state <= S_REL;
                    end
                end
                S_REL: begin
                    if (tick) begin
                        acc <= bus.add_res;
                        if (wrapped) begin
                            wrap <= 1'b1;
                            tone <= ~tone;
                        end
                    end
                    // Re-press wins; otherwise stop on the falling tone edge.
                    if (key_on)                        state <= S_RUN;
                    else if (tick && wrapped && tone)  state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
